// File: rtl/parking_sensor_conditioner_if.sv
// Signal bundle between the raw beam sensors / error-clear source and the
// conditioner that feeds clean levels and occupancy to the gate FSM.
interface parking_sensor_conditioner_if #(
  parameter int CNT_W = 4
);
  logic             raw_enterance;
  logic             raw_exit;
  logic             raw_depart;
  logic             err_clr;
  logic             sensor_enterance;
  logic             sensor_exit;
  logic             arrive_pulse;
  logic             depart_pulse;
  logic [CNT_W-1:0] occupancy;
  logic             lot_full;
  logic             lot_empty;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output raw_enterance, raw_exit, raw_depart, err_clr,
    input  sensor_enterance, sensor_exit, arrive_pulse, depart_pulse,
    input  occupancy, lot_full, lot_empty, overflow_err, underflow_err
  );

  modport slave (
    input  raw_enterance, raw_exit, raw_depart, err_clr,
    output sensor_enterance, sensor_exit, arrive_pulse, depart_pulse,
    output occupancy, lot_full, lot_empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/parking_sensor_conditioner.sv
// Synchronises and debounces the approach, pass-through and lot-exit beams,
// and keeps a saturating lot occupancy count with sticky over/underflow flags.
module parking_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  parking_sensor_conditioner_if.slave  bus
);
  localparam int               DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]    CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(CAPACITY);

  // Channel order: 0 = approach, 1 = pass-through, 2 = lot-exit.
  logic [2:0] raw;
  logic [2:0] deb_lvl;
  logic [2:0] rise;

  assign raw = {bus.raw_depart, bus.raw_exit, bus.raw_enterance};

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_dly_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // A return to the current level before the count completes restarts it.
    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q + DW'(1);
      if (s2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= raw[gi];
        s2_q      <= s1_q;
        deb_q     <= deb_d;
        deb_dly_q <= deb_q;
        cnt_q     <= cnt_d;
      end
    end

    assign deb_lvl[gi] = deb_q;
    assign rise[gi]    = deb_q & ~deb_dly_q;
  end

  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
  logic             arrive;
  logic             depart;
  logic             lot_full;
  logic             lot_empty;

  assign arrive    = rise[1];
  assign depart    = rise[2];
  assign lot_full  = (occ_q == OCC_MAX);
  assign lot_empty = (occ_q == '0);

  // Simultaneous arrival and departure cancel; a new error wins over err_clr.
  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q & ~bus.err_clr;
    unf_d = unf_q & ~bus.err_clr;
    if (arrive && !depart) begin
      if (lot_full) ovf_d = 1'b1;
      else          occ_d = occ_q + CNT_W'(1);
    end else if (depart && !arrive) begin
      if (lot_empty) unf_d = 1'b1;
      else           occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.sensor_enterance = deb_lvl[0] & ~lot_full;
  assign bus.sensor_exit      = deb_lvl[1];
  assign bus.arrive_pulse     = arrive;
  assign bus.depart_pulse     = depart;
  assign bus.occupancy        = occ_q;
  assign bus.lot_full         = lot_full;
  assign bus.lot_empty        = lot_empty;
  assign bus.overflow_err     = ovf_q;
  assign bus.underflow_err    = unf_q;
endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Directed and randomized checks of the sensor conditioner against a
// window-based behavioural model of debounce and occupancy rules.
module tb_parking_sensor_conditioner;
  localparam int DC  = 4;
  localparam int CAP = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parking_sensor_conditioner_if #(.CNT_W(CW)) bus ();

  parking_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CAPACITY(CAP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .bus(bus)
  );

  // Reference model: raw samples per edge, debounced levels, occupancy.
  logic [2:0] samp_q[$];
  logic [2:0] deb_m;
  logic [2:0] prev_m;
  int         occ_m;
  bit         ovf_m;
  bit         unf_m;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i < DC + 2; i++) samp_q.push_back(3'b000);
    deb_m  = '0;
    prev_m = '0;
    occ_m  = 0;
    ovf_m  = 0;
    unf_m  = 0;
  endtask

  // A debounced level flips once the synchronised input (raw delayed by two
  // edges) has disagreed with it for DC consecutive edges.
  task automatic model_edge();
    logic [2:0] raw_now;
    bit arr;
    bit dep;
    raw_now = {bus.raw_depart, bus.raw_exit, bus.raw_enterance};
    arr = deb_m[1] && !prev_m[1];
    dep = deb_m[2] && !prev_m[2];
    if (bus.err_clr) begin
      ovf_m = 0;
      unf_m = 0;
    end
    if (arr && !dep) begin
      if (occ_m == CAP) ovf_m = 1;
      else occ_m = occ_m + 1;
    end else if (dep && !arr) begin
      if (occ_m == 0) unf_m = 1;
      else occ_m = occ_m - 1;
    end
    samp_q.push_back(raw_now);
    prev_m = deb_m;
    for (int ch = 0; ch < 3; ch++) begin
      bit all_diff;
      all_diff = 1;
      for (int k = 2; k <= DC + 1; k++)
        if (samp_q[samp_q.size() - 1 - k][ch] == deb_m[ch]) all_diff = 0;
      if (all_diff) deb_m[ch] = ~deb_m[ch];
    end
    while (samp_q.size() > 32) void'(samp_q.pop_front());
  endtask

  task automatic compare_all();
    check("sensor_enterance", int'(bus.sensor_enterance), int'(deb_m[0] && occ_m != CAP));
    check("sensor_exit",      int'(bus.sensor_exit),      int'(deb_m[1]));
    check("arrive_pulse",     int'(bus.arrive_pulse),     int'(deb_m[1] && !prev_m[1]));
    check("depart_pulse",     int'(bus.depart_pulse),     int'(deb_m[2] && !prev_m[2]));
    check("occupancy",        int'(bus.occupancy),        occ_m);
    check("lot_full",         int'(bus.lot_full),         int'(occ_m == CAP));
    check("lot_empty",        int'(bus.lot_empty),        int'(occ_m == 0));
    check("overflow_err",     int'(bus.overflow_err),     int'(ovf_m));
    check("underflow_err",    int'(bus.underflow_err),    int'(unf_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_raw(input bit e, input bit x, input bit d);
    bus.raw_enterance = e;
    bus.raw_exit      = x;
    bus.raw_depart    = d;
  endtask

  task automatic hold(input bit e, input bit x, input bit d, input int n);
    set_raw(e, x, d);
    repeat (n) step();
  endtask

  // Assert immediately, check cleared outputs, release between edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_occupancy", int'(bus.occupancy), 0);
    check("rst_lot_empty", int'(bus.lot_empty), 1);
    check("rst_sensor_enterance", int'(bus.sensor_enterance), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic err_clear();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    set_raw(0, 0, 0);
    bus.err_clr = 1'b0;

    // 1: latency of a clean pass-through
    set_raw(0, 1, 0);
    do_reset();
    repeat (5) step();
    check("t1_exit_edge5", int'(bus.sensor_exit), 0);
    step();
    check("t1_exit_edge6", int'(bus.sensor_exit), 1);
    check("t1_arrive_edge6", int'(bus.arrive_pulse), 1);
    step();
    check("t1_arrive_edge7", int'(bus.arrive_pulse), 0);
    check("t1_occ", int'(bus.occupancy), 1);
    hold(0, 0, 0, 8);
    $display("tb: test1 latency done");

    // 2: fast toggling approach never qualifies
    for (int i = 0; i < 20; i++) begin
      hold(i[0] ? 1'b0 : 1'b1, 0, 0, 2);
      check("t2_sensor_enterance", int'(bus.sensor_enterance), 0);
      check("t2_occ", int'(bus.occupancy), 1);
    end
    hold(0, 0, 0, 4);
    $display("tb: test2 glitch rejection done");

    // 3: fill the lot, then overflow
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      hold(0, 1, 0, 8);
      hold(0, 0, 0, 8);
    end
    check("t3_occ_full", int'(bus.occupancy), CAP);
    check("t3_lot_full", int'(bus.lot_full), 1);
    hold(1, 0, 0, 10);
    check("t3_sensor_enterance_gated", int'(bus.sensor_enterance), 0);
    hold(1, 1, 0, 8);
    hold(0, 0, 0, 8);
    check("t3_occ_after_9th", int'(bus.occupancy), CAP);
    check("t3_overflow", int'(bus.overflow_err), 1);
    $display("tb: test3 fill/overflow done");

    // 5a: simultaneous arrive/depart at full
    err_clear();
    check("t5_ovf_cleared", int'(bus.overflow_err), 0);
    hold(0, 1, 1, 8);
    hold(0, 0, 0, 8);
    check("t5_occ_full", int'(bus.occupancy), CAP);
    check("t5_no_ovf", int'(bus.overflow_err), 0);
    check("t5_no_unf", int'(bus.underflow_err), 0);
    $display("tb: test5a simultaneous at full done");

    // 4: underflow then err_clr
    do_reset();
    hold(0, 0, 1, 8);
    hold(0, 0, 0, 8);
    check("t4_underflow", int'(bus.underflow_err), 1);
    check("t4_occ", int'(bus.occupancy), 0);
    err_clear();
    check("t4_unf_cleared", int'(bus.underflow_err), 0);
    $display("tb: test4 underflow done");

    // 5b: simultaneous at empty
    hold(0, 1, 1, 8);
    hold(0, 0, 0, 8);
    check("t5b_occ_empty", int'(bus.occupancy), 0);
    check("t5b_no_unf", int'(bus.underflow_err), 0);
    check("t5b_no_ovf", int'(bus.overflow_err), 0);
    $display("tb: test5b simultaneous at empty done");

    // 6: reset mid-debounce with occupancy 5
    for (int i = 0; i < 5; i++) begin
      hold(0, 1, 0, 8);
      hold(0, 0, 0, 8);
    end
    check("t6_occ5", int'(bus.occupancy), 5);
    hold(1, 0, 0, 4);
    do_reset();
    repeat (5) step();
    check("t6_ent_edge5", int'(bus.sensor_enterance), 0);
    step();
    check("t6_ent_edge6", int'(bus.sensor_enterance), 1);
    hold(0, 0, 0, 8);
    $display("tb: test6 reset mid-operation done");

    // Random phase: level flips, short glitches, occasional err_clr and reset
    for (int c = 0; c < 1200; c++) begin
      logic [2:0] lv;
      lv = {bus.raw_depart, bus.raw_exit, bus.raw_enterance};
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 9) == 0) lv[ch] = ~lv[ch];
      set_raw(lv[0], lv[1], lv[2]);
      bus.err_clr = ($urandom_range(0, 24) == 0);
      if (c == 600) begin
        bus.err_clr = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    bus.err_clr = 1'b0;
    $display("tb: random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
